matrix_row_driver: RTL and testbench

Scan driver for the 16x16 LED game-board matrix. It sits directly downstream of the game-board address counter, which walks 0x0100–0x01FF.
- It pulses `adv` to step the counter and samples the board RAM word at each address.
- It assembles one 16-pixel row in a fetch buffer while the previous row is on the display buffer.
- It drives the matrix as one active-low row strobe plus 16 column lines.

---
 rtl/matrix_pkg.sv | 25 ++
 rtl/matrix_row_driver_if.sv | 22 ++
 rtl/matrix_dwell_timer.sv | 29 ++
 rtl/matrix_row_driver.sv | 105 ++++++++++
 tb/tb_matrix_row_driver.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared constants, scan states and row-strobe helper for the LED matrix driver
package matrix_pkg;

  localparam logic [7:0]  BOARD_PAGE = 8'h01;
  localparam int          MATRIX_DIM = 16;
  localparam logic [15:0] ROW_BLANK  = 16'hFFFF;

  typedef enum logic [2:0] {
    SETTLE    = 3'd0,
    CAPTURE   = 3'd1,
    ROW_READY = 3'd2,
    BLANK     = 3'd3,
    STEP_HI   = 3'd4,
    STEP_LO   = 3'd5
  } scan_state_t;

  // Active-low one-hot strobe for a given row index.
  function automatic logic [MATRIX_DIM-1:0] row_strobe(input logic [3:0] row);
    logic [MATRIX_DIM-1:0] one_hot;
    one_hot      = '0;
    one_hot[row] = 1'b1;
    return ~one_hot;
  endfunction

endpackage

// File: rtl/matrix_row_driver_if.sv
// rtl/matrix_row_driver_if.sv - counter/RAM/matrix signal bundle between the scan driver and its neighbours
interface matrix_row_driver_if #(
  parameter int DATA_W = 16
);
  logic [15:0]       pix_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              adv;
  logic [15:0]       row_n;
  logic [15:0]       col;
  logic              frame_start;
  logic              sync_err;

  modport master (
    input  pix_addr, mem_rdata,
    output adv, row_n, col, frame_start, sync_err
  );

  modport slave (
    output pix_addr, mem_rdata,
    input  adv, row_n, col, frame_start, sync_err
  );
endinterface

// File: rtl/matrix_dwell_timer.sv
// rtl/matrix_dwell_timer.sv - loadable down-counter that saturates at zero and flags done there
module matrix_dwell_timer #(
  parameter int DWELL_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_arduino,
  input  logic i_load,
  output logic o_done
);

  localparam int                CNT_W    = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0]  LOAD_VAL = CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // Reset to zero so the first fetched row is swapped in without waiting.
  always_ff @(posedge clk or negedge reset_arduino) begin
    if (!reset_arduino) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/matrix_row_driver.sv
// rtl/matrix_row_driver.sv - steps the board address counter, double-buffers one row and strobes it onto the matrix
module matrix_row_driver
  import matrix_pkg::*;
#(
  parameter int DWELL_CYCLES = 1024,
  parameter int DATA_W       = 16
) (
  input  logic                clk,
  input  logic                reset_arduino,
  matrix_row_driver_if.master bus
);

  scan_state_t           r_state;
  scan_state_t           w_next;
  logic [MATRIX_DIM-1:0] r_fetch_buf;
  logic [3:0]            r_fetch_row;
  logic [MATRIX_DIM-1:0] r_disp_buf;
  logic [3:0]            r_disp_row;
  logic                  r_disp_valid;
  logic                  r_frame_start;
  logic                  r_sync_err;

  logic [DATA_W-1:0]     w_rdata;
  logic                  w_window_ok;
  logic                  w_pixel;
  logic [3:0]            w_col_idx;
  logic [3:0]            w_row_idx;
  logic                  w_dwell_load;
  logic                  w_dwell_done;

  assign w_rdata      = bus.mem_rdata;
  assign w_window_ok  = (bus.pix_addr[15:8] == BOARD_PAGE);
  assign w_pixel      = w_window_ok && (w_rdata != '0);
  assign w_col_idx    = bus.pix_addr[3:0];
  assign w_row_idx    = bus.pix_addr[7:4];
  assign w_dwell_load = (r_state == BLANK);

  matrix_dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell (
    .clk          (clk),
    .reset_arduino(reset_arduino),
    .i_load       (w_dwell_load),
    .o_done       (w_dwell_done)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      SETTLE:    w_next = CAPTURE;
      CAPTURE:   w_next = (w_col_idx == 4'hF) ? ROW_READY : STEP_HI;
      ROW_READY: if (w_dwell_done) w_next = BLANK;
      BLANK:     w_next = STEP_HI;
      STEP_HI:   w_next = STEP_LO;
      STEP_LO:   w_next = SETTLE;
      default:   w_next = SETTLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_arduino) begin
    if (!reset_arduino) begin
      r_state       <= SETTLE;
      r_fetch_buf   <= '0;
      r_fetch_row   <= '0;
      r_disp_buf    <= '0;
      r_disp_row    <= '0;
      r_disp_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_frame_start <= 1'b0;
      case (r_state)
        CAPTURE: begin
          // Out-of-window captures still land in the buffer, forced dark.
          r_fetch_buf[w_col_idx] <= w_pixel;
          r_fetch_row            <= w_row_idx;
          if (!w_window_ok) r_sync_err <= 1'b1;
        end
        BLANK: begin
          r_disp_buf    <= r_fetch_buf;
          r_disp_row    <= r_fetch_row;
          r_disp_valid  <= 1'b1;
          r_fetch_buf   <= '0;
          r_frame_start <= (r_fetch_row == 4'd0);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.row_n = ROW_BLANK;
    bus.col   = '0;
    if (r_disp_valid && (r_state != BLANK)) begin
      bus.row_n = row_strobe(r_disp_row);
      bus.col   = r_disp_buf;
    end
  end

  assign bus.adv         = (r_state == STEP_HI);
  assign bus.frame_start = r_frame_start;
  assign bus.sync_err    = r_sync_err;

endmodule

// File: tb/tb_matrix_row_driver.sv
// tb/tb_matrix_row_driver.sv - directed bench with counter/RAM models for two dwell settings
module tb_matrix_row_driver;

  logic clk = 1'b0;
  logic reset_arduino = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  matrix_row_driver_if #(.DATA_W(16)) bus0 ();
  matrix_row_driver_if #(.DATA_W(16)) bus1 ();

  matrix_row_driver #(.DWELL_CYCLES(64), .DATA_W(16)) dut0 (
    .clk(clk), .reset_arduino(reset_arduino), .bus(bus0)
  );
  matrix_row_driver #(.DWELL_CYCLES(100), .DATA_W(16)) dut1 (
    .clk(clk), .reset_arduino(reset_arduino), .bus(bus1)
  );

  // Address counter and 1-cycle-latency board RAM models
  logic [15:0] cnt0, cnt1;
  logic [15:0] rd0 = 16'h0, rd1 = 16'h0;
  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];
  logic        force0 = 1'b0;

  always @(posedge clk or negedge reset_arduino)
    if (!reset_arduino) cnt0 <= 16'h0100;
    else if (bus0.adv) cnt0 <= (cnt0 == 16'h01FF) ? 16'h0100 : cnt0 + 16'd1;
  always @(posedge clk or negedge reset_arduino)
    if (!reset_arduino) cnt1 <= 16'h0100;
    else if (bus1.adv) cnt1 <= (cnt1 == 16'h01FF) ? 16'h0100 : cnt1 + 16'd1;
  always @(posedge clk) rd0 <= mem0[bus0.pix_addr[7:0]];
  always @(posedge clk) rd1 <= mem1[bus1.pix_addr[7:0]];

  assign bus0.pix_addr  = force0 ? 16'h0203 : cnt0;
  assign bus0.mem_rdata = rd0;
  assign bus1.pix_addr  = cnt1;
  assign bus1.mem_rdata = rd1;

  // Monitors: record each lit row as {row_n, col} on its first lit cycle
  logic [31:0] lit0[$];
  logic [31:0] lit1[$];
  int          len1[$];
  int          gap1[$];
  logic [15:0] prev_rn0 = 16'hFFFF, prev_rn1 = 16'hFFFF;
  logic        prev_fs0 = 1'b0, prev_adv0 = 1'b0;
  int          run1 = 0, cyc0 = 0, last_adv0 = 0;
  int          adv0_first = 0, adv0_bad = 0, fs0_cnt = 0, fs0_bad = 0;

  always @(negedge clk) begin
    if (bus0.row_n != 16'hFFFF && prev_rn0 == 16'hFFFF) lit0.push_back({bus0.row_n, bus0.col});
    if (bus0.frame_start) begin
      fs0_cnt <= fs0_cnt + 1;
      if (bus0.row_n != 16'hFFFE || prev_fs0) fs0_bad <= fs0_bad + 1;
    end
    if (bus0.adv) begin
      if (prev_adv0) adv0_bad <= adv0_bad + 1;
      if (lit0.size() == 0) begin
        if (adv0_first > 0 && (cyc0 - last_adv0) != 4) adv0_bad <= adv0_bad + 1;
        adv0_first <= adv0_first + 1;
      end
      last_adv0 <= cyc0;
    end
    prev_rn0  <= bus0.row_n;
    prev_fs0  <= bus0.frame_start;
    prev_adv0 <= bus0.adv;
    cyc0      <= cyc0 + 1;
  end

  always @(negedge clk) begin
    if (bus1.row_n != 16'hFFFF) begin
      if (prev_rn1 == 16'hFFFF) begin
        if (lit1.size() > 0) gap1.push_back(run1);
        lit1.push_back({bus1.row_n, bus1.col});
        run1 <= 1;
      end else run1 <= run1 + 1;
    end else begin
      if (prev_rn1 != 16'hFFFF) begin
        len1.push_back(run1);
        run1 <= 1;
      end else run1 <= run1 + 1;
    end
    prev_rn1 <= bus1.row_n;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          inst;
    int          idx;
    logic [15:0] row_n;
    logic [15:0] col;
  } vec_t;
  vec_t vecs[11];

  initial begin
    int n;
    logic [31:0] got;
    vecs[0]  = '{0, 0,  16'hFFFE, 16'h0001};
    vecs[1]  = '{0, 1,  16'hFFFD, 16'h0002};
    vecs[2]  = '{0, 3,  16'hFFF7, 16'h0000};
    vecs[3]  = '{0, 4,  16'hFFEF, 16'h0010};
    vecs[4]  = '{0, 5,  16'hFFDF, 16'h0020};
    vecs[5]  = '{0, 15, 16'h7FFF, 16'h8000};
    vecs[6]  = '{0, 16, 16'hFFFE, 16'h0001};
    vecs[7]  = '{1, 0,  16'hFFFE, 16'hFFFF};
    vecs[8]  = '{1, 1,  16'hFFFD, 16'hFFFE};
    vecs[9]  = '{1, 2,  16'hFFFB, 16'hFFFC};
    vecs[10] = '{1, 3,  16'hFFF7, 16'hFFF8};
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        mem0[16*r+c] = (c == r) ? (16'h0001 << r) : 16'h0000;
        mem1[16*r+c] = (c >= r) ? 16'(c + 1) : 16'h0000;
      end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_row_n0", bus0.row_n, 16'hFFFF);
    chk("reset_col0", bus0.col, 16'h0);
    chk("reset_adv0", bus0.adv, 1'b0);
    chk("reset_frame_start0", bus0.frame_start, 1'b0);
    chk("reset_sync_err0", bus0.sync_err, 1'b0);
    chk("reset_row_n1", bus1.row_n, 16'hFFFF);

    reset_arduino = 1'b1;
    @(negedge clk);
    chk("adv_low_after_edge1", bus0.adv, 1'b0);

    // Corrupt the capture of row 3 column 3 with an off-page address
    n = 0;
    while (cnt0 != 16'h0133 && n < 2000) begin @(negedge clk); n++; end
    chk("force_point_reached", n < 2000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("sync_err_before_force", bus0.sync_err, 1'b0);
    force0 = 1'b1;
    @(negedge clk);
    force0 = 1'b0;
    chk("sync_err_set", bus0.sync_err, 1'b1);

    n = 0;
    while ((lit0.size() < 17 || lit1.size() < 5) && n < 4000) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("rows_displayed", n < 4000, 1'b1);

    for (int i = 0; i < 11; i++) begin
      n = (vecs[i].inst == 0) ? lit0.size() : lit1.size();
      chk($sformatf("present_i%0d_r%0d", vecs[i].inst, vecs[i].idx), n > vecs[i].idx, 1'b1);
      if (n > vecs[i].idx) begin
        got = (vecs[i].inst == 0) ? lit0[vecs[i].idx] : lit1[vecs[i].idx];
        chk($sformatf("row_n_i%0d_r%0d", vecs[i].inst, vecs[i].idx), got[31:16], vecs[i].row_n);
        chk($sformatf("col_i%0d_r%0d", vecs[i].inst, vecs[i].idx), got[15:0], vecs[i].col);
      end
    end

    chk("adv_pulses_first_row", adv0_first, 15);
    chk("adv_shape_errors", adv0_bad, 0);
    chk("frame_start_count", fs0_cnt, 2);
    chk("frame_start_misaligned", fs0_bad, 0);
    chk("sync_err_sticky", bus0.sync_err, 1'b1);
    chk("sync_err_other_clean", bus1.sync_err, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("lit_len_%0d", i), (len1.size() > i) ? len1[i] : -1, 100);
      chk($sformatf("blank_len_%0d", i), (gap1.size() > i) ? gap1[i] : -1, 1);
    end

    // Asynchronous reset while fetching row 3 column 7
    n = 0;
    while (cnt0 != 16'h0137 && n < 2000) begin @(negedge clk); n++; end
    chk("midrow_point_reached", n < 2000, 1'b1);
    chk("midrow_lit_row2", bus0.row_n, 16'hFFFB);
    reset_arduino = 1'b0;
    #1;
    chk("async_row_n0", bus0.row_n, 16'hFFFF);
    chk("async_col0", bus0.col, 16'h0);
    chk("async_adv0", bus0.adv, 1'b0);
    chk("async_sync_err0", bus0.sync_err, 1'b0);
    chk("async_row_n1", bus1.row_n, 16'hFFFF);
    @(negedge clk);
    @(negedge clk);
    lit0.delete();
    reset_arduino = 1'b1;
    n = 0;
    while (lit0.size() < 1 && n < 500) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("post_reset_row_seen", lit0.size() > 0, 1'b1);
    if (lit0.size() > 0) chk("post_reset_first_row", lit0[0], {16'hFFFE, 16'h0001});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
